// File: rtl/mux_scanner_pkg.sv
// Purpose: shared types and constants for the 4-channel mux scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mux_scanner_pkg;

    // Channel count and default settle time per channel.
    localparam int NCH           = 4;
    localparam int DWELL_DEFAULT = 4;

    // Dwell counter width; 8 bits covers the largest legal DWELL of 255.
    localparam int DWELL_W = 8;

    // Width of a channel index.
    localparam int CH_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/dwell_timer.sv
// Purpose: settle-time counter; counts edges on a channel and flags the last one.
// Latency: tc is combinational from the count register; it rises on the LIMIT-th enabled edge.
// Backpressure: none; load has priority and holds the count at zero.
//
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   load       : force count to zero (used whenever the scanner is not settling)
//   en         : count this edge
//   tc         : count has reached LIMIT-1, i.e. this is the LIMIT-th edge
module dwell_timer #(
    parameter int LIMIT = 4,
    parameter int W     = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic tc
);

    logic [W-1:0] count;

    assign tc = (count == W'(LIMIT - 1));

    // Wrap to zero on terminal count so the next channel starts a fresh dwell
    // without an extra load cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load || (en && tc)) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mux_scanner.sv
// Purpose: walks the enabled channels of a 4:1 mux, samples each after DWELL cycles, returns one word.
// Latency: sample_valid rises N*DWELL edges after the edge that accepts start (N = enabled channels).
// Backpressure: result held in DONE until sample_ready; start is not accepted until then.
//
// Ports:
//   clk, reset            : clock and asynchronous active-high reset
//   start, chan_mask      : scan request and channel enables (sampled only in IDLE)
//   mux_out               : downstream mux output, driven by select
//   select                : current channel index to the mux
//   sample_data           : one bit per channel, disabled channels read 0
//   sample_valid/ready    : result handshake
//   busy                  : high whenever not idle
module mux_scanner #(
    parameter int DWELL = mux_scanner_pkg::DWELL_DEFAULT,
    parameter int NCH   = mux_scanner_pkg::NCH
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [NCH-1:0] chan_mask,
    input  logic           mux_out,
    output logic [1:0]     select,
    output logic [NCH-1:0] sample_data,
    output logic           sample_valid,
    input  logic           sample_ready,
    output logic           busy
);

    import mux_scanner_pkg::*;

    state_t         state;
    logic [NCH-1:0] mask_q;
    logic           tc;

    logic [CH_W-1:0] first_ch;
    logic            first_any;
    logic [CH_W-1:0] next_ch;
    logic            next_any;

    // Counter is parked at zero outside SETTLE so every scan starts clean.
    dwell_timer #(
        .LIMIT (DWELL),
        .W     (DWELL_W)
    ) u_dwell (
        .clk   (clk),
        .reset (reset),
        .load  (state != ST_SETTLE),
        .en    (state == ST_SETTLE),
        .tc    (tc)
    );

    // Priority pickers: descending loops so the lowest qualifying index wins.
    // first_* looks at the live mask for the start decision; next_* looks at
    // the latched mask strictly above the current channel, so no wrap-around.
    always_comb begin
        first_ch  = '0;
        first_any = 1'b0;
        next_ch   = '0;
        next_any  = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (chan_mask[i]) begin
                first_any = 1'b1;
                first_ch  = i[CH_W-1:0];
            end
            if (mask_q[i] && (i > int'(select))) begin
                next_any = 1'b1;
                next_ch  = i[CH_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            mask_q       <= '0;
            select       <= '0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // An empty mask is a no-op request.
                    if (start && first_any) begin
                        mask_q      <= chan_mask;
                        sample_data <= '0;
                        select      <= first_ch;
                        busy        <= 1'b1;
                        state       <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    // Capture and move on in the same edge: no gap between channels.
                    if (tc) begin
                        sample_data[select] <= mux_out;
                        if (next_any) begin
                            select <= next_ch;
                        end else begin
                            sample_valid <= 1'b1;
                            state        <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // select keeps the last channel until the word is taken.
                    if (sample_ready) begin
                        sample_valid <= 1'b0;
                        select       <= '0;
                        busy         <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scanner.sv
// Purpose: directed self-checking bench for mux_scanner with a behavioural 4:1 mux.
// Latency: checks select every cycle and sample_valid at exactly N*DWELL edges.
// Backpressure: holds sample_ready low in DONE and checks the result stays put.
module tb_mux_scanner;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] chan_mask;
    logic       mux_out;
    logic [1:0] select;
    logic [3:0] sample_data;
    logic       sample_valid;
    logic       sample_ready;
    logic       busy;

    logic [3:0] mux_in;

    int checks   = 0;
    int failures = 0;

    mux_scanner #(
        .DWELL (4),
        .NCH   (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .chan_mask    (chan_mask),
        .mux_out      (mux_out),
        .select       (select),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy)
    );

    // Downstream 4:1 mux model.
    assign mux_out = mux_in[select];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [3:0] exp_data);
        chk({tag, "_select"}, 32'(select), 32'd0);
        chk({tag, "_valid"}, 32'(sample_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_data"}, 32'(sample_data), 32'(exp_data));
    endtask

    // seq packs the visited channel indices, 2 bits each, first channel in [1:0].
    // With disturb set, start, chan_mask and sample_ready are wiggled mid-scan.
    task automatic do_scan(input logic [3:0] mask, input logic [7:0] seq, input int n,
                           input logic [3:0] exp_data, input bit disturb, input string tag);
        chan_mask = mask;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < n * 4; k++) begin
            chk({tag, "_select"}, 32'(select), 32'(seq[2*(k/4) +: 2]));
            chk({tag, "_valid_early"}, 32'(sample_valid), 32'd0);
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            if (disturb && k == 5) begin
                start        = 1'b1;
                chan_mask    = 4'b0001;
                sample_ready = 1'b1;
            end
            if (disturb && k == 6) begin
                start        = 1'b0;
                sample_ready = 1'b0;
            end
            step();
        end
        chk({tag, "_valid"}, 32'(sample_valid), 32'd1);
        chk({tag, "_data"}, 32'(sample_data), 32'(exp_data));
        chk({tag, "_busy_done"}, 32'(busy), 32'd1);
        chk({tag, "_select_done"}, 32'(select), 32'(seq[2*(n-1) +: 2]));
    endtask

    // Hold ready low for 'hold' cycles, then complete the handshake.
    task automatic handshake(input int hold, input logic [3:0] exp_data,
                             input logic [1:0] last_sel, input string tag);
        sample_ready = 1'b0;
        for (int j = 0; j < hold; j++) begin
            step();
            chk({tag, "_hold_valid"}, 32'(sample_valid), 32'd1);
            chk({tag, "_hold_data"}, 32'(sample_data), 32'(exp_data));
            chk({tag, "_hold_select"}, 32'(select), 32'(last_sel));
        end
        sample_ready = 1'b1;
        step();
        sample_ready = 1'b0;
        chk_idle({tag, "_after"}, exp_data);
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        chan_mask    = 4'b0000;
        sample_ready = 1'b0;
        mux_in       = 4'b0000;

        // Reset state, during and after reset.
        step();
        step();
        chk_idle("reset_held", 4'b0000);
        reset = 1'b0;
        step();
        chk_idle("reset_released", 4'b0000);

        // Empty mask with start is ignored.
        chan_mask = 4'b0000;
        start     = 1'b1;
        step();
        step();
        start = 1'b0;
        chk_idle("empty_mask", 4'b0000);

        // Full scan, then 10 cycles of backpressure.
        mux_in = 4'b1010;
        do_scan(4'b1111, 8'b11_10_01_00, 4, 4'b1010, 1'b0, "full");
        handshake(10, 4'b1010, 2'd3, "full_bp");

        // Back-to-back start in the first IDLE cycle, with mid-scan disturbance.
        do_scan(4'b1111, 8'b11_10_01_00, 4, 4'b1010, 1'b1, "b2b_disturb");
        handshake(0, 4'b1010, 2'd3, "b2b_hs");

        // Sparse mask: bits 1 and 3 were 1 last scan and must now read 0.
        mux_in = 4'b1111;
        do_scan(4'b0101, 8'b00_00_10_00, 2, 4'b0101, 1'b0, "sparse");
        handshake(2, 4'b0101, 2'd2, "sparse_hs");

        // Only the top channel.
        do_scan(4'b1000, 8'b00_00_00_11, 1, 4'b1000, 1'b0, "top_only");
        handshake(0, 4'b1000, 2'd3, "top_hs");

        // Asynchronous reset mid-scan.
        mux_in    = 4'b1010;
        chan_mask = 4'b1111;
        start     = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        chk("midscan_select_pre", 32'(select), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_idle("async_reset", 4'b0000);
        step();
        reset = 1'b0;
        step();
        chk_idle("post_reset", 4'b0000);
        do_scan(4'b1111, 8'b11_10_01_00, 4, 4'b1010, 1'b0, "after_reset");
        handshake(1, 4'b1010, 2'd3, "after_reset_hs");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
